// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong frame buffer.
//   rd_state_t  : read-side FSM states
//   clog2_min1  : ceil(log2(n)), never less than 1 (used for index port widths)
//   OVR_MAX     : saturation value of the overrun counter
package pingpong_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        FETCH   = 3'd2,
        STREAM  = 3'd3,
        RELEASE = 3'd4
    } rd_state_t;

    localparam logic [15:0] OVR_MAX = 16'hFFFF;

    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM holding one half (even or odd samples) of a frame bank.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears read register only)
//   we, waddr, wdata: write port
//   raddr, rdata    : read port, rdata registered with one-cycle latency
module frame_bank_ram
    import pingpong_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [clog2_min1(DEPTH)-1:0] waddr,
    input  logic [W-1:0]                 wdata,
    input  logic [clog2_min1(DEPTH)-1:0] raddr,
    output logic [W-1:0]                 rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= {W{1'b0}};
        end else begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Ping-pong frame collector between the I2S receiver and the DFT core.
// Captures one channel (or a mono mix of all channels), decimates, converts to
// OUT_W bits and fills two alternating frame banks; each full frame is streamed
// as even/odd sample pairs with a valid/ready handshake.
// Optional build macro: PINGPONG_ROUND_EN -- round-half-up with positive
// saturation instead of truncation, plus one extra write-path register.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ch/in_data     : interleaved channel sample stream
//   mix_mode, ch_sel           : capture mode (latched at channel 0)
//   frame_start                : one-cycle pulse two cycles before the first pair
//   out_valid/out_ready        : pair handshake
//   out_even/out_odd/out_last  : sample pair, last flag on the final pair
//   overrun_cnt                : dropped-sample count, saturating
//   frame_cnt                  : frames fully streamed, wrapping
module pingpong_frame_buffer
    import pingpong_pkg::*;
#(
    parameter int IN_W      = 24,
    parameter int OUT_W     = 16,
    parameter int FRAME_LEN = 512,
    parameter int DECIM     = 8,
    parameter int NUM_CH    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [clog2_min1(NUM_CH)-1:0] in_ch,
    input  logic signed [IN_W-1:0]        in_data,
    input  logic                          mix_mode,
    input  logic [clog2_min1(NUM_CH)-1:0] ch_sel,
    output logic                          frame_start,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_even,
    output logic [OUT_W-1:0]              out_odd,
    output logic                          out_last,
    output logic [15:0]                   overrun_cnt,
    output logic [15:0]                   frame_cnt
);

    localparam int CH_W    = clog2_min1(NUM_CH);
    localparam int LOG2_CH = $clog2(NUM_CH);
    localparam int ACC_W   = IN_W + LOG2_CH;
    localparam int IDX_W   = $clog2(FRAME_LEN);
    localparam int AW      = IDX_W - 1;
    localparam int HALF    = FRAME_LEN / 2;
    localparam int DEC_W   = clog2_min1(DECIM);

    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [AW-1:0]    LAST_PAIR = AW'(HALF - 1);
    localparam logic [DEC_W-1:0] LAST_DEC  = DEC_W'(DECIM - 1);

    // ---------------- sample production ----------------
    logic                    mix_r;
    logic [CH_W-1:0]         sel_r;
    logic                    eff_mix_s;
    logic [CH_W-1:0]         eff_sel_s;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] sum_s;
    logic                    prod_valid_s;
    logic signed [IN_W-1:0]  prod_data_s;

    // Effective mode (new settings apply from channel 0) and produced sample
    always_comb begin
        eff_mix_s    = (in_ch == {CH_W{1'b0}}) ? mix_mode : mix_r;
        eff_sel_s    = (in_ch == {CH_W{1'b0}}) ? ch_sel : sel_r;
        sum_s        = acc_r + ACC_W'(in_data);
        prod_valid_s = in_valid && (eff_mix_s ? (in_ch == LAST_CH) : (in_ch == eff_sel_s));
        prod_data_s  = eff_mix_s ? IN_W'(sum_s >>> LOG2_CH) : in_data;
    end

    // Mode latch at channel 0 and mix accumulator cleared after the last channel
    always_ff @(posedge clk) begin
        if (reset) begin
            mix_r <= 1'b0;
            sel_r <= {CH_W{1'b0}};
            acc_r <= {ACC_W{1'b0}};
        end else if (in_valid) begin
            if (in_ch == {CH_W{1'b0}}) begin
                mix_r <= mix_mode;
                sel_r <= ch_sel;
            end
            acc_r <= (in_ch == LAST_CH) ? {ACC_W{1'b0}} : sum_s;
        end
    end

    // ---------------- decimation ----------------
    logic [DEC_W-1:0] dec_cnt_r;
    logic             keep_s;

    assign keep_s = prod_valid_s && (dec_cnt_r == {DEC_W{1'b0}});

    // Decimation counter advances on every produced sample
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_cnt_r <= {DEC_W{1'b0}};
        end else if (prod_valid_s) begin
            dec_cnt_r <= (dec_cnt_r == LAST_DEC) ? {DEC_W{1'b0}} : dec_cnt_r + DEC_W'(1);
        end
    end

    // ---------------- width conversion ----------------
    logic             wr_valid_s;
    logic [OUT_W-1:0] wr_data_s;

`ifdef PINGPONG_ROUND_EN
    localparam int             RND_BIT = (IN_W > OUT_W) ? IN_W - OUT_W - 1 : 0;
    localparam logic [IN_W:0]  RND_ADD = (IN_W > OUT_W) ? ((IN_W + 1)'(1'b1) << RND_BIT)
                                                        : {(IN_W + 1){1'b0}};
    logic [IN_W:0]    rnd_sum_s;
    logic [OUT_W-1:0] conv_s;
    logic             keep_r;
    logic [OUT_W-1:0] conv_r;

    // Round half up; only a non-negative sample can carry into the sign bit
    always_comb begin
        rnd_sum_s = {prod_data_s[IN_W-1], prod_data_s} + RND_ADD;
        if (!prod_data_s[IN_W-1] && rnd_sum_s[IN_W-1]) begin
            conv_s = {1'b0, {(OUT_W - 1){1'b1}}};
        end else begin
            conv_s = rnd_sum_s[IN_W-1 -: OUT_W];
        end
    end

    // Pipeline register after rounding
    always_ff @(posedge clk) begin
        if (reset) begin
            keep_r <= 1'b0;
            conv_r <= {OUT_W{1'b0}};
        end else begin
            keep_r <= keep_s;
            conv_r <= conv_s;
        end
    end

    assign wr_valid_s = keep_r;
    assign wr_data_s  = conv_r;
`else
    assign wr_valid_s = keep_s;
    assign wr_data_s  = prod_data_s[IN_W-1 -: OUT_W];
`endif

    // ---------------- write side ----------------
    rd_state_t        state_r;
    logic             rb_r;
    logic             wb_r;
    logic [IDX_W-1:0] wr_idx_r;
    logic [1:0]       full_r;
    logic [1:0]       full_eff_s;
    logic             tgt_s;
    logic             do_wr_s;
    logic             drop_s;
    logic             frame_done_s;

    // A release in this cycle already counts; when the write bank is full but
    // the other one has just been freed, writing moves to the freed bank.
    always_comb begin
        full_eff_s   = full_r & ~((state_r == RELEASE) ? (2'b01 << rb_r) : 2'b00);
        tgt_s        = (full_eff_s[wb_r] && !full_eff_s[~wb_r]) ? ~wb_r : wb_r;
        do_wr_s      = wr_valid_s && !full_eff_s[tgt_s];
        drop_s       = wr_valid_s && full_eff_s[tgt_s];
        frame_done_s = do_wr_s && (wr_idx_r == LAST_IDX);
    end

    // Bank bookkeeping, write index and overrun counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_r        <= 1'b0;
            wr_idx_r    <= {IDX_W{1'b0}};
            full_r      <= 2'b00;
            overrun_cnt <= 16'd0;
        end else begin
            full_r <= full_eff_s | (frame_done_s ? (2'b01 << tgt_s) : 2'b00);
            if (frame_done_s) begin
                wr_idx_r <= {IDX_W{1'b0}};
                wb_r     <= full_eff_s[~tgt_s] ? tgt_s : ~tgt_s;
            end else begin
                wb_r <= tgt_s;
                if (do_wr_s) begin
                    wr_idx_r <= wr_idx_r + IDX_W'(1);
                end
            end
            if (drop_s && (overrun_cnt != OVR_MAX)) begin
                overrun_cnt <= overrun_cnt + 16'd1;
            end
        end
    end

    // ---------------- bank RAMs ----------------
    logic [AW-1:0]    rd_addr_r;
    logic [AW-1:0]    ram_raddr_s;
    logic             hs_s;
    logic [OUT_W-1:0] rd_s [2][2];

    assign hs_s = out_valid && out_ready;
    // Present the next address during the handshake so the pair gap is one cycle
    assign ram_raddr_s = ((state_r == STREAM) && hs_s && !out_last) ? rd_addr_r + AW'(1)
                                                                    : rd_addr_r;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar p = 0; p < 2; p++) begin : g_par
            frame_bank_ram #(
                .DEPTH(HALF),
                .W    (OUT_W)
            ) u_ram (
                .clk  (clk),
                .reset(reset),
                .we   (do_wr_s && (tgt_s == 1'(b)) && (wr_idx_r[0] == 1'(p))),
                .waddr(wr_idx_r[IDX_W-1:1]),
                .wdata(wr_data_s),
                .raddr(ram_raddr_s),
                .rdata(rd_s[b][p])
            );
        end
    end

    // ---------------- read FSM ----------------
    // Streams the frame in bank rb as pairs, then releases the bank
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            rb_r        <= 1'b0;
            rd_addr_r   <= {AW{1'b0}};
            frame_start <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_even    <= {OUT_W{1'b0}};
            out_odd     <= {OUT_W{1'b0}};
            frame_cnt   <= 16'd0;
        end else begin
            frame_start <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (full_r[rb_r]) begin
                        state_r     <= START;
                        frame_start <= 1'b1;
                        rd_addr_r   <= {AW{1'b0}};
                    end
                end
                START: begin
                    state_r <= FETCH;
                end
                FETCH: begin
                    out_even  <= rb_r ? rd_s[1][0] : rd_s[0][0];
                    out_odd   <= rb_r ? rd_s[1][1] : rd_s[0][1];
                    out_last  <= (rd_addr_r == LAST_PAIR);
                    out_valid <= 1'b1;
                    state_r   <= STREAM;
                end
                STREAM: begin
                    if (hs_s) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state_r <= RELEASE;
                        end else begin
                            rd_addr_r <= rd_addr_r + AW'(1);
                            state_r   <= FETCH;
                        end
                    end
                end
                RELEASE: begin
                    rb_r      <= ~rb_r;
                    frame_cnt <= frame_cnt + 16'd1;
                    rd_addr_r <= {AW{1'b0}};
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Self-checking bench for pingpong_frame_buffer: a vector table of constant-input
// frames checks the mix/select/width conversion, followed by directed sequences
// for ramp order, latency, decimation, backpressure/overrun and reset mid-stream.
module tb_pingpong_frame_buffer;

    localparam int IN_W  = 24;
    localparam int OUT_W = 16;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic [0:0]       in_ch     = 1'b0;
    logic [IN_W-1:0]  in_data   = 24'h0;
    logic             mix_mode  = 1'b0;
    logic [0:0]       ch_sel    = 1'b0;
    logic             out_ready = 1'b0;

    logic             frame_start, out_valid, out_last;
    logic [OUT_W-1:0] out_even, out_odd;
    logic [15:0]      overrun_cnt, frame_cnt;

    logic             d_frame_start, d_out_valid, d_out_last;
    logic [OUT_W-1:0] d_out_even, d_out_odd;
    logic [15:0]      d_overrun_cnt, d_frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fs_cyc = -100;
    int lat    = -1;
    bit lat_pend = 1'b0;
    logic [32:0] q[$];
    logic [32:0] qd[$];
    int          hs_cyc[$];

    typedef struct {
        logic        mix;
        logic        sel;
        logic [23:0] d0;
        logic [23:0] d1;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[9];

    pingpong_frame_buffer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .FRAME_LEN(8), .DECIM(1), .NUM_CH(2)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .mix_mode(mix_mode), .ch_sel(ch_sel), .frame_start(frame_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_even(out_even),
        .out_odd(out_odd), .out_last(out_last), .overrun_cnt(overrun_cnt),
        .frame_cnt(frame_cnt)
    );

    pingpong_frame_buffer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .FRAME_LEN(8), .DECIM(8), .NUM_CH(2)
    ) dut_d (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .mix_mode(mix_mode), .ch_sel(ch_sel), .frame_start(d_frame_start),
        .out_valid(d_out_valid), .out_ready(out_ready), .out_even(d_out_even),
        .out_odd(d_out_odd), .out_last(d_out_last), .overrun_cnt(d_overrun_cnt),
        .frame_cnt(d_frame_cnt)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pair monitor and frame_start-to-valid latency measurement
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q.push_back({out_last, out_odd, out_even});
            hs_cyc.push_back(cyc);
        end
        if (d_out_valid && out_ready) begin
            qd.push_back({d_out_last, d_out_odd, d_out_even});
        end
        if (frame_start) begin
            fs_cyc   = cyc;
            lat_pend = 1'b1;
        end else if (out_valid && lat_pend) begin
            lat      = cyc - fs_cyc;
            lat_pend = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete(); qd.delete(); hs_cyc.delete();
    endtask

    task automatic send_frame(input logic mix, input logic sel,
                              input logic [23:0] b0, input logic [23:0] s0,
                              input logic [23:0] b1, input logic [23:0] s1, input int n);
        mix_mode = mix;
        ch_sel   = sel;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_ch = 1'b0; in_data = b0 + 24'(i) * s0;
            @(posedge clk); #1;
            in_ch = 1'b1; in_data = b1 + 24'(i) * s1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_pairs(input int n, input bit use_d, input string name);
        int k = 0;
        while (((use_d ? qd.size() : q.size()) < n) && (k < 400)) begin
            @(posedge clk);
            k++;
        end
        check({name, "_pair_count"}, 64'((use_d ? qd.size() : q.size()) >= n), 64'd1);
    endtask

    function automatic logic [32:0] get_pair(input bit use_d, input int idx);
        if (use_d) begin
            return (idx < qd.size()) ? qd[idx] : {33{1'bx}};
        end else begin
            return (idx < q.size()) ? q[idx] : {33{1'bx}};
        end
    endfunction

    task automatic check_pair(input string name, input bit use_d, input int idx,
                              input logic [15:0] ev, input logic [15:0] od, input logic last);
        check($sformatf("%s_pair%0d", name, idx), 64'(get_pair(use_d, idx)), 64'({last, od, ev}));
    endtask

    initial begin
        int k;
        vecs[0] = '{1'b1, 1'b0, 24'h000100, 24'h000300, 16'h0002};
        vecs[1] = '{1'b0, 1'b0, 24'h123456, 24'hABCD12, 16'h1234};
        vecs[2] = '{1'b0, 1'b1, 24'h123456, 24'hABCD12, 16'hABCD};
        vecs[3] = '{1'b1, 1'b0, 24'hFFFF00, 24'hFFFD00, 16'hFFFE};
        vecs[4] = '{1'b1, 1'b0, 24'h7FFFFF, 24'h7FFFFF, 16'h7FFF};
        vecs[5] = '{1'b1, 1'b0, 24'h800000, 24'h800000, 16'h8000};
        vecs[6] = '{1'b0, 1'b0, 24'h7FFF80, 24'h111111, 16'h7FFF};
`ifdef PINGPONG_ROUND_EN
        vecs[7] = '{1'b0, 1'b0, 24'h000080, 24'h222222, 16'h0001};
        vecs[8] = '{1'b0, 1'b1, 24'h333333, 24'hFFFFFF, 16'h0000};
`else
        vecs[7] = '{1'b0, 1'b0, 24'h000080, 24'h222222, 16'h0000};
        vecs[8] = '{1'b0, 1'b1, 24'h333333, 24'hFFFFFF, 16'hFFFF};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({frame_start, out_valid, out_last, out_even, out_odd, overrun_cnt, frame_cnt}),
              64'd0);

        // Constant-input frames through the conversion path
        for (int i = 0; i < 9; i++) begin
            do_reset();
            out_ready = 1'b1;
            send_frame(vecs[i].mix, vecs[i].sel, vecs[i].d0, 24'h0, vecs[i].d1, 24'h0, 8);
            wait_pairs(4, 1'b0, $sformatf("vec%0d", i));
            for (int j = 0; j < 4; j++) begin
                check_pair($sformatf("vec%0d", i), 1'b0, j, vecs[i].exp, vecs[i].exp, j == 3);
            end
        end

        // Select mode ramp on ch1, ch0 garbage
        do_reset();
        out_ready = 1'b1;
        send_frame(1'b0, 1'b1, 24'hDEAD00, 24'h000111, 24'h0, 24'h000100, 8);
        wait_pairs(4, 1'b0, "ramp");
        for (int j = 0; j < 4; j++) begin
            check_pair("ramp", 1'b0, j, 16'(2 * j), 16'(2 * j + 1), j == 3);
        end
        check("start_to_valid_latency", 64'(lat), 64'd2);
        check("pair_gap_cycles", 64'((hs_cyc.size() > 1) ? hs_cyc[1] - hs_cyc[0] : -1), 64'd2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("ramp_frame_cnt", 64'(frame_cnt), 64'd1);

        // Decimation by 8 on ch0
        do_reset();
        out_ready = 1'b1;
        send_frame(1'b0, 1'b0, 24'h0, 24'h000100, 24'h5A5A00, 24'h0, 64);
        wait_pairs(4, 1'b1, "decim");
        for (int j = 0; j < 4; j++) begin
            check_pair("decim", 1'b1, j, 16'(16 * j), 16'(16 * j + 8), j == 3);
        end

        // Backpressure with three frames written: third one overruns
        do_reset();
        send_frame(1'b0, 1'b1, 24'hDEAD00, 24'h0, 24'h0, 24'h000100, 24);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("bp_hold_a", 64'({out_valid, out_last, out_even, out_odd}), 64'({1'b1, 1'b0, 16'd0, 16'd1}));
        repeat (3) @(negedge clk);
        check("bp_hold_b", 64'({out_valid, out_last, out_even, out_odd}), 64'({1'b1, 1'b0, 16'd0, 16'd1}));
        check("bp_overrun_cnt", 64'(overrun_cnt), 64'd8);
        check("bp_frame_cnt_0", 64'(frame_cnt), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_pairs(8, 1'b0, "bp");
        for (int j = 0; j < 8; j++) begin
            check_pair("bp", 1'b0, j, 16'(2 * j), 16'(2 * j + 1), (j % 4) == 3);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_frame_cnt_2", 64'(frame_cnt), 64'd2);
        check("bp_no_third_frame", 64'({q.size() == 8, out_valid}), 64'({1'b1, 1'b0}));
        send_frame(1'b0, 1'b1, 24'h0, 24'h0, 24'h004000, 24'h000100, 8);
        wait_pairs(12, 1'b0, "resume");
        check_pair("resume", 1'b0, 8, 16'h0040, 16'h0041, 1'b0);
        check_pair("resume", 1'b0, 11, 16'h0046, 16'h0047, 1'b1);
        check("resume_overrun_cnt", 64'(overrun_cnt), 64'd8);

        // Reset in the middle of a streamed frame
        do_reset();
        out_ready = 1'b1;
        send_frame(1'b0, 1'b1, 24'h0, 24'h0, 24'h0, 24'h000100, 8);
        k = 0;
        while ((q.size() < 2) && (k < 400)) begin
            @(posedge clk);
            k++;
        end
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midreset_outputs",
              64'({frame_start, out_valid, out_last, out_even, out_odd, overrun_cnt, frame_cnt}),
              64'd0);
        check("midreset_two_pairs_no_last",
              64'({q.size() == 2, get_pair(1'b0, 0) >> 32, get_pair(1'b0, 1) >> 32}),
              64'({1'b1, 33'd0, 33'd0}));
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete(); hs_cyc.delete();
        send_frame(1'b0, 1'b1, 24'h0, 24'h0, 24'h002000, 24'h000100, 8);
        wait_pairs(4, 1'b0, "fresh");
        for (int j = 0; j < 4; j++) begin
            check_pair("fresh", 1'b0, j, 16'(32 + 2 * j), 16'(33 + 2 * j), j == 3);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("fresh_frame_cnt", 64'(frame_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
